// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings: ALU opcodes, shift types, B-bus sources and the
// data-processing sequencer state and captured-instruction types.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
        ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
        ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
        ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'd0,
        SHIFT_LSR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_type_t;

    typedef enum logic [1:0] {
        B_NONE = 2'd0,
        B_RM   = 2'd1,
        B_RS   = 2'd2,
        B_IMM  = 2'd3
    } b_src_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RS_FETCH = 2'd1,
        EXEC     = 2'd2,
        SKIP     = 2'd3
    } dp_seq_state_t;

    typedef struct packed {
        alu_op_t     opcode;
        logic        s_bit;
        logic        imm_op;
        logic [3:0]  rot_imm;
        logic        reg_shift;
        shift_type_t shift_type;
        logic [4:0]  shift_imm;
        logic        cpsr_c;
    } dp_instr_t;

    // Compare/test ops update flags only and never write Rd.
    function automatic logic is_test_op(alu_op_t op);
        return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
    endfunction

endpackage

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: drives ALU and
// shifter control, B-bus source select and Rd/CPSR write enables.
module dp_sequencer
    import cpu_types_pkg::*;
#(
    parameter bit RS_EXTRA_CYCLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       ready,
    input  logic       cond_pass,
    input  logic [3:0] opcode,
    input  logic       s_bit,
    input  logic       imm_op,
    input  logic [3:0] rot_imm,
    input  logic       reg_shift,
    input  logic [1:0] shift_type_in,
    input  logic [4:0] shift_imm,
    input  logic       cpsr_c,
    output logic [3:0] alu_op,
    output logic       alu_carry_in,
    output logic       latch_op_b,
    output logic       use_op_b_latch,
    output logic       disable_op_b,
    output logic [4:0] shift_amount,
    output logic [1:0] shift_type,
    output logic       shift_carry_in,
    output logic       latch_shift_amt,
    output logic       use_shift_latch,
    output logic [1:0] b_src,
    output logic       rd_we,
    output logic       flags_we,
    output logic       done
);

    dp_seq_state_t state_q, state_d;
    dp_instr_t     instr_q;
    logic          accept;

    assign accept = start && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            // Outputs are driven only from this snapshot, so the decoder may move on.
            if (accept) begin
                instr_q <= '{opcode:     alu_op_t'(opcode),
                             s_bit:      s_bit,
                             imm_op:     imm_op,
                             rot_imm:    rot_imm,
                             reg_shift:  reg_shift,
                             shift_type: shift_type_t'(shift_type_in),
                             shift_imm:  shift_imm,
                             cpsr_c:     cpsr_c};
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        ready           = 1'b0;
        alu_op          = 4'h0;
        alu_carry_in    = 1'b0;
        latch_op_b      = 1'b0;
        use_op_b_latch  = 1'b0;
        disable_op_b    = 1'b0;
        shift_amount    = 5'd0;
        shift_type      = 2'd0;
        shift_carry_in  = 1'b0;
        latch_shift_amt = 1'b0;
        use_shift_latch = 1'b0;
        b_src           = B_NONE;
        rd_we           = 1'b0;
        flags_we        = 1'b0;
        done            = 1'b0;

        case (state_q)
            IDLE: begin
                ready        = 1'b1;
                disable_op_b = 1'b1;
                if (start) begin
                    if (!cond_pass)
                        state_d = SKIP;
                    else if (RS_EXTRA_CYCLE && reg_shift && !imm_op)
                        state_d = RS_FETCH;
                    else
                        state_d = EXEC;
                end
            end
            RS_FETCH: begin
                b_src           = B_RS;
                latch_shift_amt = 1'b1;
                disable_op_b    = 1'b1;
                state_d         = EXEC;
            end
            EXEC: begin
                alu_op         = instr_q.opcode;
                alu_carry_in   = instr_q.cpsr_c;
                shift_carry_in = instr_q.cpsr_c;
                done           = 1'b1;
                // Immediate operand wins over reg_shift: the rotate is a fixed ROR by 2*rot.
                if (instr_q.imm_op) begin
                    b_src        = B_IMM;
                    shift_type   = SHIFT_ROR;
                    shift_amount = {instr_q.rot_imm, 1'b0};
                end else if (instr_q.reg_shift) begin
                    b_src           = B_RM;
                    shift_type      = instr_q.shift_type;
                    use_shift_latch = 1'b1;
                end else begin
                    b_src        = B_RM;
                    shift_type   = instr_q.shift_type;
                    shift_amount = instr_q.shift_imm;
                end
                rd_we    = !is_test_op(instr_q.opcode);
                flags_we = instr_q.s_bit || is_test_op(instr_q.opcode);
                state_d  = IDLE;
            end
            SKIP: begin
                done         = 1'b1;
                disable_op_b = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Randomized self-checking bench for dp_sequencer against a per-cycle
// behavioural model of the instruction timeline.
module tb_dp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready;
    logic       cond_pass = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       s_bit = 1'b0;
    logic       imm_op = 1'b0;
    logic [3:0] rot_imm = 4'h0;
    logic       reg_shift = 1'b0;
    logic [1:0] shift_type_in = 2'd0;
    logic [4:0] shift_imm = 5'd0;
    logic       cpsr_c = 1'b0;
    logic [3:0] alu_op;
    logic       alu_carry_in, latch_op_b, use_op_b_latch, disable_op_b;
    logic [4:0] shift_amount;
    logic [1:0] shift_type;
    logic       shift_carry_in, latch_shift_amt, use_shift_latch;
    logic [1:0] b_src;
    logic       rd_we, flags_we, done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       cond;
        logic [3:0] op;
        logic       s;
        logic       imm;
        logic [3:0] rot;
        logic       rs;
        logic [1:0] st;
        logic [4:0] simm;
        logic       c;
    } ins_t;

    logic [23:0] obs;
    assign obs = {ready, alu_op, alu_carry_in, latch_op_b, use_op_b_latch, disable_op_b,
                  shift_amount, shift_type, shift_carry_in, latch_shift_amt, use_shift_latch,
                  b_src, rd_we, flags_we, done};

    dp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .cond_pass(cond_pass),
        .opcode(opcode), .s_bit(s_bit), .imm_op(imm_op), .rot_imm(rot_imm),
        .reg_shift(reg_shift), .shift_type_in(shift_type_in), .shift_imm(shift_imm),
        .cpsr_c(cpsr_c), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
        .latch_op_b(latch_op_b), .use_op_b_latch(use_op_b_latch),
        .disable_op_b(disable_op_b), .shift_amount(shift_amount), .shift_type(shift_type),
        .shift_carry_in(shift_carry_in), .latch_shift_amt(latch_shift_amt),
        .use_shift_latch(use_shift_latch), .b_src(b_src), .rd_we(rd_we),
        .flags_we(flags_we), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] vec(logic rdy, logic [3:0] op, logic aci, logic dis,
                                        logic [4:0] samt, logic [1:0] st, logic sci,
                                        logic lsa, logic usl, logic [1:0] b,
                                        logic rd, logic fl, logic dn);
        return {rdy, op, aci, 1'b0, 1'b0, dis, samt, st, sci, lsa, usl, b, rd, fl, dn};
    endfunction

    function automatic logic [23:0] idle_vec();
        return vec(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic int lat(ins_t in);
        if (!in.cond) return 1;
        return (in.rs && !in.imm) ? 2 : 1;
    endfunction

    // Expected outputs c cycles after acceptance; c==0 or beyond the latency is idle.
    function automatic logic [23:0] model(ins_t in, int c);
        logic       cmp;
        logic [4:0] samt;
        if (c == 0 || c > lat(in)) return idle_vec();
        if (!in.cond) return vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (in.rs && !in.imm && c == 1) return vec(0, 0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0);
        cmp = (in.op >= 4'd8) && (in.op <= 4'd11);
        samt = in.imm ? 5'(in.rot * 2) : (in.rs ? 5'd0 : in.simm);
        return vec(0, in.op, in.c, 0, samt, in.imm ? 2'd3 : in.st, in.c, 0,
                   !in.imm && in.rs, in.imm ? 2'd3 : 2'd1, !cmp, in.s || cmp, 1);
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r = ins_t'($urandom);
        r.cond = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    task automatic scramble();
        ins_t g;
        g = ins_t'($urandom);
        cond_pass = g.cond; opcode = g.op; s_bit = g.s; imm_op = g.imm; rot_imm = g.rot;
        reg_shift = g.rs; shift_type_in = g.st; shift_imm = g.simm; cpsr_c = g.c;
    endtask

    task automatic set_inputs(input ins_t in);
        cond_pass = in.cond; opcode = in.op; s_bit = in.s; imm_op = in.imm; rot_imm = in.rot;
        reg_shift = in.rs; shift_type_in = in.st; shift_imm = in.simm; cpsr_c = in.c;
    endtask

    task automatic drive(input ins_t in);
        set_inputs(in);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, idle_vec());
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_imm();
        ins_t in;
        in = '{cond: 1, op: 4'h4, s: 0, imm: 1, rot: 4'd4, rs: 0, st: 2'd1, simm: 5'd9, c: 1};
        drive(in);
        for (int c = 1; c <= lat(in) + 1; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model(in, c)) begin
                errors++;
                $display("[TB] FAIL imm_add cyc%0d: got %h expected %h", c, obs, model(in, c));
            end
            if (c == 1) begin
                checks++;
                if (shift_amount !== 5'd8 || b_src !== 2'd3 || shift_type !== 2'd3) begin
                    errors++;
                    $display("[TB] FAIL imm_rotate: got amt=%0d b=%0d st=%0d expected amt=8 b=3 st=3",
                             shift_amount, b_src, shift_type);
                end
            end
        end
    endtask

    task automatic test_imm_shift();
        ins_t in;
        in = '{cond: 1, op: 4'h2, s: 1, imm: 0, rot: 4'd7, rs: 0, st: 2'd0, simm: 5'd3, c: 0};
        drive(in);
        for (int c = 1; c <= lat(in) + 1; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model(in, c)) begin
                errors++;
                $display("[TB] FAIL sub_lsl3 cyc%0d: got %h expected %h", c, obs, model(in, c));
            end
        end
    endtask

    task automatic test_reg_shift();
        ins_t in;
        in = '{cond: 1, op: 4'h4, s: 0, imm: 0, rot: 4'd2, rs: 1, st: 2'd0, simm: 5'd17, c: 1};
        drive(in);
        for (int c = 1; c <= lat(in) + 1; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model(in, c)) begin
                errors++;
                $display("[TB] FAIL add_lsl_rs cyc%0d: got %h expected %h", c, obs, model(in, c));
            end
        end
    endtask

    task automatic test_test_ops();
        ins_t in;
        for (int op = 8; op <= 11; op++) begin
            in = '{cond: 1, op: 4'(op), s: 0, imm: 0, rot: 4'd0, rs: 0, st: 2'd2, simm: 5'd0, c: 1};
            drive(in);
            for (int c = 1; c <= lat(in) + 1; c++) begin
                @(negedge clk);
                checks++;
                if (obs !== model(in, c)) begin
                    errors++;
                    $display("[TB] FAIL test_op%0d cyc%0d: got %h expected %h", op, c, obs, model(in, c));
                end
            end
        end
    endtask

    task automatic test_cond_fail();
        ins_t in;
        in = '{cond: 0, op: 4'h4, s: 1, imm: 0, rot: 4'd0, rs: 1, st: 2'd1, simm: 5'd5, c: 1};
        drive(in);
        for (int c = 1; c <= lat(in) + 1; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model(in, c)) begin
                errors++;
                $display("[TB] FAIL cond_skip cyc%0d: got %h expected %h", c, obs, model(in, c));
            end
        end
    endtask

    task automatic test_reset_mid();
        ins_t in, nxt;
        in = '{cond: 1, op: 4'h4, s: 1, imm: 0, rot: 4'd0, rs: 1, st: 2'd3, simm: 5'd0, c: 0};
        drive(in);
        @(negedge clk);
        checks++;
        if (obs !== model(in, 1)) begin
            errors++;
            $display("[TB] FAIL mid_rs_fetch: got %h expected %h", obs, model(in, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", obs, idle_vec());
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || rd_we !== 1'b0 || flags_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_done: got done=%b rd=%b fl=%b expected 0 0 0",
                         done, rd_we, flags_we);
            end
        end
        rst_n = 1'b1;
        nxt = '{cond: 1, op: 4'hD, s: 1, imm: 1, rot: 4'd15, rs: 1, st: 2'd0, simm: 5'd0, c: 1};
        drive(nxt);
        for (int c = 1; c <= lat(nxt) + 1; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model(nxt, c)) begin
                errors++;
                $display("[TB] FAIL after_reset cyc%0d: got %h expected %h", c, obs, model(nxt, c));
            end
        end
    endtask

    // start stays high throughout; busy cycles see garbage inputs that must be ignored.
    task automatic test_back_to_back();
        ins_t q[$];
        q.push_back('{cond: 1, op: 4'h4, s: 0, imm: 1, rot: 4'd1, rs: 0, st: 2'd0, simm: 5'd0, c: 0});
        q.push_back('{cond: 1, op: 4'h2, s: 1, imm: 0, rot: 4'd0, rs: 1, st: 2'd1, simm: 5'd0, c: 1});
        q.push_back('{cond: 0, op: 4'hC, s: 1, imm: 0, rot: 4'd0, rs: 1, st: 2'd2, simm: 5'd4, c: 1});
        for (int k = 0; k < 5; k++) q.push_back(rand_ins());
        foreach (q[k]) begin
            set_inputs(q[k]);
            start = 1'b1;
            checks++;
            if (obs !== idle_vec()) begin
                errors++;
                $display("[TB] FAIL b2b_idle%0d: got %h expected %h", k, obs, idle_vec());
            end
            @(posedge clk);
            #1;
            scramble();
            for (int c = 1; c <= lat(q[k]); c++) begin
                @(negedge clk);
                checks++;
                if (obs !== model(q[k], c)) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d cyc%0d: got %h expected %h", k, c, obs, model(q[k], c));
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        ins_t in;
        for (int n = 0; n < 60; n++) begin
            in = rand_ins();
            drive(in);
            for (int c = 1; c <= lat(in) + 1; c++) begin
                @(negedge clk);
                checks++;
                if (obs !== model(in, c)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d cyc%0d: got %h expected %h", n, c, obs, model(in, c));
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_imm();
        test_imm_shift();
        test_reg_shift();
        test_test_ops();
        test_cond_fail();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle controller that sequences the ALU and barrel shifter for ARM data-processing instructions.
- Accepts a decoded instruction on a start/ready handshake and drives the control side of ALU_if and Shifter_if.
- Selects which register drives the B bus, and issues the Rd write-enable and CPSR flag write-enable.
- Sits between the control unit and the ALU/shifter datapath.

Parameters:
- RS_EXTRA_CYCLE, 1, 1 = register-specified shift takes a separate Rs fetch cycle; 0 = illegal (reserved).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to execute the presented instruction
- ready  out  1  sequencer idle; start accepted when start&ready
- cond_pass  in  1  condition check result for the instruction
- opcode  in  4  data-processing opcode (alu_op_t encoding)
- s_bit  in  1  set-flags bit
- imm_op  in  1  operand 2 is rotated 8-bit immediate
- rot_imm  in  4  immediate rotate field
- reg_shift  in  1  shift amount comes from Rs
- shift_type_in  in  2  shift_type_t from IR[6:5]
- shift_imm  in  5  immediate shift amount IR[11:7]
- cpsr_c  in  1  current carry flag
- alu_op  out  4  to ALU_if
- alu_carry_in  out  1  to ALU_if
- latch_op_b, use_op_b_latch, disable_op_b  out  1 each  to ALU_if
- shift_amount  out  5  to Shifter_if
- shift_type  out  2  to Shifter_if
- shift_carry_in  out  1  to Shifter_if
- latch_shift_amt, use_shift_latch  out  1 each  to Shifter_if
- b_src  out  2  b_src_t: B_NONE, B_RM, B_RS, B_IMM
- rd_we  out  1  write ALU result to Rd this cycle
- flags_we  out  1  write ALU flags_out to CPSR this cycle
- done  out  1  one-cycle pulse, instruction complete

Behaviour:
- States (dp_seq_state_t): IDLE, RS_FETCH, EXEC, SKIP.
- Reset (async, rst_n=0): state=IDLE.
  - ready=1 and disable_op_b=1.
  - All other outputs 0; b_src=B_NONE.
- Input capture:
  - All instruction inputs, including cpsr_c, are registered on the accepting edge (start&ready).
  - Outputs derive only from captured copies.
- IDLE:
  - ready=1; disable_op_b=1.
  - On start:
    - !cond_pass -> SKIP.
    - else reg_shift&!imm_op -> RS_FETCH.
    - else -> EXEC.
  - start while not ready is ignored; no queueing.
- RS_FETCH (1 cycle):
  - b_src=B_RS; latch_shift_amt=1; disable_op_b=1.
  - rd_we=0, flags_we=0.
  - -> EXEC.
- EXEC (1 cycle):
  - alu_op=opcode; alu_carry_in=cpsr_c; shift_carry_in=cpsr_c; done=1.
  - Operand-2 source:
    - imm_op: b_src=B_IMM; shift_type=ROR; shift_amount={rot_imm,1'b0}.
    - reg_shift: b_src=B_RM; shift_type=shift_type_in; use_shift_latch=1.
    - else: b_src=B_RM; shift_type=shift_type_in; shift_amount=shift_imm.
  - rd_we=1 unless opcode is TST/TEQ/CMP/CMN.
  - flags_we=s_bit; forced 1 for TST/TEQ/CMP/CMN.
  - -> IDLE.
- SKIP (1 cycle): done=1; rd_we=0; flags_we=0; disable_op_b=1; -> IDLE.
- Latency, start to done:
  - immediate or imm-shift: 1 cycle.
  - register shift: 2 cycles.
  - condition fail: 1 cycle.
- Back-to-back: ready is high in IDLE only, so maximum throughput is one instruction per 2 cycles (imm) or 3 cycles (reg shift).
- Shift-amount special cases (LSR/ASR #0 meaning #32, ROR #0 meaning RRX) are passed through unchanged; the shifter owns their interpretation.
- latch_op_b and use_op_b_latch are held 0; they are reserved for multiply sequencing.
- Reset mid-instruction: immediate return to IDLE; no done, no rd_we, no flags_we.

Decomposition:
- cpu_types_pkg additions:
  - dp_seq_state_t.
  - b_src_t.
  - is_test_op(alu_op_t) function.
  - SHIFT_ROR constant alias, if not already present.
- No sub-module: a single FSM plus capture registers.

Test Plan:
- ADD imm, rot_imm=4, s_bit=0, cond_pass=1 -> EXEC 1 cycle after start: b_src=B_IMM, shift_type=ROR, shift_amount=8, rd_we=1, flags_we=0, done=1.
- SUB Rm LSL #3, s_bit=1 -> EXEC: shift_amount=3, b_src=B_RM, rd_we=1, flags_we=1; ready returns 1 the next cycle.
- ADD Rm LSL Rs -> cycle 1: b_src=B_RS, latch_shift_amt=1, rd_we=0. Cycle 2: b_src=B_RM, use_shift_latch=1, rd_we=1, done=1.
- CMP with s_bit=0, cpsr_c=1 -> rd_we=0, flags_we=1, alu_carry_in=1.
- cond_pass=0 on a reg-shift ADD -> SKIP: done=1 at cycle 1, no RS_FETCH, rd_we=flags_we=0 throughout.
- rst_n low during RS_FETCH -> outputs return to reset values asynchronously; no done pulse; a start after release is accepted normally.
